reg_scoreboard: RTL and testbench

- Register-hazard controller between the Decode and Data-Fetch/Schedule stages; replaces the single-bit occupancy vector.
- Tracks outstanding in-flight writes per GPR with saturating counters.
- Grants or stalls issue of each micro-op and releases registers on writeback.
- Sequences a pipeline flush/drain after a taken branch, call or ret.

---
 rtl/reg_scoreboard_pkg.sv | 23 ++
 rtl/reg_scoreboard_counter.sv | 46 ++++
 rtl/reg_scoreboard.sv | 112 +++++++++++
 tb/tb_reg_scoreboard.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_scoreboard_pkg.sv
// Shared constants and types for the register-hazard scoreboard.
// The GPR indices follow the x86 register encoding used by decode.
package reg_scoreboard_pkg;

  localparam int NREGS     = 32;
  localparam int REG_IDX_W = 5;
  localparam int CNT_W     = 2;

  typedef enum logic [0:0] {
    SB_IDLE  = 1'b0,
    SB_DRAIN = 1'b1
  } sb_state_t;

  localparam logic [REG_IDX_W-1:0] GPR_RAX = 5'd0;
  localparam logic [REG_IDX_W-1:0] GPR_RCX = 5'd1;
  localparam logic [REG_IDX_W-1:0] GPR_RDX = 5'd2;
  localparam logic [REG_IDX_W-1:0] GPR_RBX = 5'd3;
  localparam logic [REG_IDX_W-1:0] GPR_RSP = 5'd4;
  localparam logic [REG_IDX_W-1:0] GPR_RBP = 5'd5;
  localparam logic [REG_IDX_W-1:0] GPR_RSI = 5'd6;
  localparam logic [REG_IDX_W-1:0] GPR_RDI = 5'd7;

endpackage

// File: rtl/reg_scoreboard_counter.sv
// Per-register pending-write counter: up by one, down by up to two, clamped to [0, max].
// Also exports the next value so the owner can register derived status from it.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic [1:0]       dec,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] cnt_next_o,
  output logic             underflow_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   sum_s, dec_s, diff_s;
  logic [CNT_W:0]   max_s;

  assign sum_s  = {1'b0, cnt_q} + {{CNT_W{1'b0}}, inc};
  assign dec_s  = {{(CNT_W-1){1'b0}}, dec};
  assign diff_s = sum_s - dec_s;
  assign max_s  = {1'b0, {CNT_W{1'b1}}};

  // Net increment against release; a release with nothing pending flags underflow.
  always_comb begin
    underflow_o = 1'b0;
    cnt_d       = cnt_q;
    if (dec_s > sum_s) begin
      underflow_o = 1'b1;
      cnt_d       = '0;
    end else if (diff_s > max_s) begin
      cnt_d = '1;
    end else begin
      cnt_d = diff_s[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o      = cnt_q;
  assign cnt_next_o = cnt_d;

endmodule

// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard: grants/stalls uop issue against pending GPR writes,
// releases on writeback, and drains the pipeline after a taken control transfer.
module reg_scoreboard #(
  parameter int NREGS  = reg_scoreboard_pkg::NREGS,
  parameter int RIDX_W = reg_scoreboard_pkg::REG_IDX_W,
  parameter int CNT_W  = reg_scoreboard_pkg::CNT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_valid,
  input  logic [2:0]          src_valid,
  input  logic [3*RIDX_W-1:0] src_idx,
  input  logic [1:0]          dst_valid,
  input  logic [2*RIDX_W-1:0] dst_idx,
  output logic                issue_fire,
  output logic                issue_stall,
  input  logic [1:0]          wb_valid,
  input  logic [2*RIDX_W-1:0] wb_idx,
  input  logic                flush,
  output logic [NREGS-1:0]    busy_vec,
  output logic                draining,
  output logic                underflow_err
);
  import reg_scoreboard_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  sb_state_t        state_q;
  logic             draining_q, underflow_q, hazard_s;
  logic [NREGS-1:0] busy_vec_q, busy_d, inc_s, uflow_s;
  logic [CNT_W-1:0] cnt_s [NREGS];
  logic [CNT_W-1:0] cnt_nxt_s [NREGS];
  logic [1:0]       dec_s [NREGS];

  // Hazards use current counters only; a same-cycle writeback is not bypassed.
  always_comb begin
    hazard_s = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (src_valid[k] && cnt_s[src_idx[k*RIDX_W +: RIDX_W]] != '0) hazard_s = 1'b1;
    end
    for (int k = 0; k < 2; k++) begin
      if (dst_valid[k] && cnt_s[dst_idx[k*RIDX_W +: RIDX_W]] == CNT_MAX) hazard_s = 1'b1;
    end
  end

  assign issue_stall = issue_valid && ((state_q == SB_DRAIN) || hazard_s);
  assign issue_fire  = issue_valid && !issue_stall;

  for (genvar r = 0; r < NREGS; r++) begin : g_reg
    // Both destinations naming the same register still count as one write.
    assign inc_s[r] = issue_fire &&
                      ((dst_valid[0] && dst_idx[0 +: RIDX_W]      == RIDX_W'(r)) ||
                       (dst_valid[1] && dst_idx[RIDX_W +: RIDX_W] == RIDX_W'(r)));
    assign dec_s[r] = {1'b0, wb_valid[0] && wb_idx[0 +: RIDX_W]      == RIDX_W'(r)} +
                      {1'b0, wb_valid[1] && wb_idx[RIDX_W +: RIDX_W] == RIDX_W'(r)};

    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk        (clk),
      .reset      (reset),
      .inc        (inc_s[r]),
      .dec        (dec_s[r]),
      .cnt_o      (cnt_s[r]),
      .cnt_next_o (cnt_nxt_s[r]),
      .underflow_o(uflow_s[r])
    );

    assign busy_d[r] = (cnt_nxt_s[r] != '0);
  end

  // Status registers: busy mirrors post-edge counters, underflow is sticky.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_vec_q  <= '0;
      underflow_q <= 1'b0;
    end else begin
      busy_vec_q  <= busy_d;
      underflow_q <= underflow_q | (|uflow_s);
    end
  end

  // Drain FSM: leave only once nothing is pending and no new flush arrives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= SB_IDLE;
      draining_q <= 1'b0;
    end else begin
      case (state_q)
        SB_IDLE: begin
          if (flush) begin
            state_q    <= SB_DRAIN;
            draining_q <= 1'b1;
          end
        end
        SB_DRAIN: begin
          if (!flush && (busy_vec_q == '0)) begin
            state_q    <= SB_IDLE;
            draining_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= SB_IDLE;
          draining_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy_vec      = busy_vec_q;
  assign draining      = draining_q;
  assign underflow_err = underflow_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard with hand-computed expectations.
module tb_reg_scoreboard;
  import reg_scoreboard_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [2:0]  src_valid;
  logic [14:0] src_idx;
  logic [1:0]  dst_valid;
  logic [9:0]  dst_idx;
  logic        issue_fire, issue_stall;
  logic [1:0]  wb_valid;
  logic [9:0]  wb_idx;
  logic        flush;
  logic [31:0] busy_vec;
  logic        draining, underflow_err;

  int n_assert = 0;
  int n_fail   = 0;

  reg_scoreboard dut (
    .clk          (clk),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .src_valid    (src_valid),
    .src_idx      (src_idx),
    .dst_valid    (dst_valid),
    .dst_idx      (dst_idx),
    .issue_fire   (issue_fire),
    .issue_stall  (issue_stall),
    .wb_valid     (wb_valid),
    .wb_idx       (wb_idx),
    .flush        (flush),
    .busy_vec     (busy_vec),
    .draining     (draining),
    .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic iv, input logic [2:0] sv, input logic [4:0] s0,
                     input logic [1:0] dv, input logic [4:0] d0, input logic [4:0] d1,
                     input logic [1:0] wv, input logic [4:0] w0, input logic [4:0] w1,
                     input logic fl);
    issue_valid = iv;
    src_valid   = sv;
    src_idx     = {5'd0, 5'd0, s0};
    dst_valid   = dv;
    dst_idx     = {d1, d0};
    wb_valid    = wv;
    wb_idx      = {w1, w0};
    flush       = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    put(1'b0, 3'b000, 5'd0, 2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 1'b0);
  endtask

  function automatic logic [31:0] bit_of(input logic [4:0] r);
    return 32'h1 << r;
  endfunction

  initial begin
    reset = 1'b0;
    idle();
    chk("rst_busy", busy_vec, 32'h0);
    chk("rst_drain", {31'd0, draining}, 32'h0);
    chk("rst_uflow", {31'd0, underflow_err}, 32'h0);
    chk("rst_fire", {31'd0, issue_fire}, 32'h0);
    chk("rst_stall", {31'd0, issue_stall}, 32'h0);
    tick();
    reset = 1'b1;

    // RAW hazard on RBX, released by writeback with no bypass
    put(1'b1, 3'b001, GPR_RAX, 2'b01, GPR_RBX, 5'd0, 2'b00, 5'd0, 5'd0, 1'b0);
    chk("c0_fire", {31'd0, issue_fire}, 32'h1);
    tick();
    chk("c1_busy_rbx", busy_vec, bit_of(GPR_RBX));
    put(1'b1, 3'b001, GPR_RBX, 2'b01, GPR_RDI, 5'd0, 2'b00, 5'd0, 5'd0, 1'b0);
    chk("c1_stall", {31'd0, issue_stall}, 32'h1);
    chk("c1_nofire", {31'd0, issue_fire}, 32'h0);
    tick();
    chk("c2_stall", {31'd0, issue_stall}, 32'h1);
    tick();
    put(1'b1, 3'b001, GPR_RBX, 2'b01, GPR_RDI, 5'd0, 2'b01, GPR_RBX, 5'd0, 1'b0);
    chk("c3_stall_nobypass", {31'd0, issue_stall}, 32'h1);
    tick();
    put(1'b1, 3'b001, GPR_RBX, 2'b01, GPR_RDI, 5'd0, 2'b00, 5'd0, 5'd0, 1'b0);
    chk("c4_busy", busy_vec, 32'h0);
    chk("c4_fire", {31'd0, issue_fire}, 32'h1);
    tick();
    chk("c5_busy_rdi", busy_vec, bit_of(GPR_RDI));
    put(1'b0, 3'b000, 5'd0, 2'b00, 5'd0, 5'd0, 2'b01, GPR_RDI, 5'd0, 1'b0);
    tick();
    chk("c6_busy_clear", busy_vec, 32'h0);

    // Push names RSP twice: counts once, so two more writers fit before saturation
    put(1'b1, 3'b000, 5'd0, 2'b11, GPR_RSP, GPR_RSP, 2'b00, 5'd0, 5'd0, 1'b0);
    chk("push_fire", {31'd0, issue_fire}, 32'h1);
    tick();
    put(1'b1, 3'b000, 5'd0, 2'b01, GPR_RSP, 5'd0, 2'b00, 5'd0, 5'd0, 1'b0);
    chk("rsp_w2_fire", {31'd0, issue_fire}, 32'h1);
    tick();
    chk("rsp_w3_fire", {31'd0, issue_fire}, 32'h1);
    tick();
    chk("rsp_sat_stall", {31'd0, issue_stall}, 32'h1);
    put(1'b0, 3'b000, 5'd0, 2'b00, 5'd0, 5'd0, 2'b11, GPR_RSP, GPR_RSP, 1'b0);
    tick();
    chk("rsp_after_dec2", busy_vec, bit_of(GPR_RSP));
    put(1'b0, 3'b000, 5'd0, 2'b00, 5'd0, 5'd0, 2'b01, GPR_RSP, 5'd0, 1'b0);
    tick();
    chk("rsp_clear", busy_vec, 32'h0);
    chk("rsp_no_uflow", {31'd0, underflow_err}, 32'h0);

    // Simultaneous issue and writeback on RCX net out
    put(1'b1, 3'b000, 5'd0, 2'b01, GPR_RCX, 5'd0, 2'b00, 5'd0, 5'd0, 1'b0);
    tick();
    put(1'b1, 3'b000, 5'd0, 2'b01, GPR_RCX, 5'd0, 2'b01, GPR_RCX, 5'd0, 1'b0);
    chk("rcx_fire", {31'd0, issue_fire}, 32'h1);
    tick();
    chk("rcx_busy_kept", busy_vec, bit_of(GPR_RCX));
    put(1'b0, 3'b000, 5'd0, 2'b00, 5'd0, 5'd0, 2'b01, GPR_RCX, 5'd0, 1'b0);
    tick();
    chk("rcx_clear", busy_vec, 32'h0);
    chk("rcx_no_uflow", {31'd0, underflow_err}, 32'h0);

    // Flush with RAX/RDX outstanding; second writer fires alongside the flush
    put(1'b1, 3'b000, 5'd0, 2'b01, GPR_RAX, 5'd0, 2'b00, 5'd0, 5'd0, 1'b0);
    tick();
    put(1'b1, 3'b000, 5'd0, 2'b01, GPR_RDX, 5'd0, 2'b00, 5'd0, 5'd0, 1'b1);
    chk("flush_fire", {31'd0, issue_fire}, 32'h1);
    tick();
    chk("drain_on", {31'd0, draining}, 32'h1);
    chk("drain_busy", busy_vec, bit_of(GPR_RAX) | bit_of(GPR_RDX));
    put(1'b1, 3'b000, 5'd0, 2'b01, GPR_RBP, 5'd0, 2'b00, 5'd0, 5'd0, 1'b0);
    chk("drain_stall", {31'd0, issue_stall}, 32'h1);
    tick();
    put(1'b1, 3'b000, 5'd0, 2'b01, GPR_RBP, 5'd0, 2'b01, GPR_RAX, 5'd0, 1'b0);
    chk("drain_nofire", {31'd0, issue_fire}, 32'h0);
    tick();
    put(1'b1, 3'b000, 5'd0, 2'b01, GPR_RBP, 5'd0, 2'b01, GPR_RDX, 5'd0, 1'b0);
    chk("drain_hold", {31'd0, draining}, 32'h1);
    tick();
    put(1'b1, 3'b000, 5'd0, 2'b01, GPR_RBP, 5'd0, 2'b00, 5'd0, 5'd0, 1'b0);
    chk("drain_zero_busy", busy_vec, 32'h0);
    chk("drain_last_stall", {31'd0, issue_stall}, 32'h1);
    tick();
    chk("drain_off", {31'd0, draining}, 32'h0);
    chk("resume_fire", {31'd0, issue_fire}, 32'h1);
    tick();
    chk("resume_busy", busy_vec, bit_of(GPR_RBP));
    put(1'b0, 3'b000, 5'd0, 2'b00, 5'd0, 5'd0, 2'b01, GPR_RBP, 5'd0, 1'b0);
    tick();

    // Flush with nothing outstanding drains for exactly one cycle
    put(1'b0, 3'b000, 5'd0, 2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 1'b1);
    tick();
    idle();
    chk("empty_drain_1", {31'd0, draining}, 32'h1);
    tick();
    chk("empty_drain_0", {31'd0, draining}, 32'h0);

    // Release of an idle register sets sticky underflow
    put(1'b0, 3'b000, 5'd0, 2'b00, 5'd0, 5'd0, 2'b01, GPR_RSI, 5'd0, 1'b0);
    tick();
    idle();
    chk("uflow_set", {31'd0, underflow_err}, 32'h1);
    chk("uflow_busy", busy_vec, 32'h0);
    tick();
    chk("uflow_sticky", {31'd0, underflow_err}, 32'h1);

    // Asynchronous reset in the middle of a drain
    put(1'b1, 3'b000, 5'd0, 2'b01, GPR_RDI, 5'd0, 2'b00, 5'd0, 5'd0, 1'b0);
    tick();
    put(1'b0, 3'b000, 5'd0, 2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 1'b1);
    tick();
    idle();
    chk("pre_rst_drain", {31'd0, draining}, 32'h1);
    chk("pre_rst_busy", busy_vec, bit_of(GPR_RDI));
    #1;
    reset = 1'b0;
    #1;
    chk("arst_busy", busy_vec, 32'h0);
    chk("arst_drain", {31'd0, draining}, 32'h0);
    chk("arst_uflow", {31'd0, underflow_err}, 32'h0);
    #1;
    reset = 1'b1;
    put(1'b1, 3'b000, 5'd0, 2'b01, GPR_RDI, 5'd0, 2'b00, 5'd0, 5'd0, 1'b0);
    chk("post_rst_fire", {31'd0, issue_fire}, 32'h1);
    tick();
    idle();
    chk("post_rst_busy", busy_vec, bit_of(GPR_RDI));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
